// File: rtl/banco_registros_param.sv
// -----------------------------------------------------------------------------
// banco_registros_param
// Parametrised RISC-V integer register file for the decode stage.
//  - N_READ combinational read ports feeding the ALU operand muxes
//  - one write port driven by writeback, optional same-cycle write->read bypass
//  - optional hardwired zero register (x0)
//  - sequential bulk-clear engine that walks every register once
//
// Ports
//  CLK         in   clock, rising edge
//  RST         in   asynchronous active-low reset
//  Add_R       in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//  Info_R      out  read data, port i at [i*DATA_W +: DATA_W]
//  Add_Dest    in   write address
//  Write_Data  in   write data
//  Write_En    in   write request
//  Clear_Req   in   start a bulk clear (ignored while one is running)
//  Busy        out  high while the clear engine runs (registered)
//  Write_Drop  out  one-cycle pulse after a write discarded during a clear
//
// Clear FSM
//  state   | meaning
//  S_IDLE  | normal operation, writes accepted
//  S_CLEAR | zeroing mem[r_ptr] each cycle, writes dropped, Busy high
// -----------------------------------------------------------------------------
module banco_registros_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_READ   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N_READ*ADDR_W-1:0]   Add_R,
   output logic [N_READ*DATA_W-1:0]   Info_R,
   input  logic [ADDR_W-1:0]          Add_Dest,
   input  logic [DATA_W-1:0]          Write_Data,
   input  logic                       Write_En,
   input  logic                       Clear_Req,
   output logic                       Busy,
   output logic                       Write_Drop
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_ptr;
   logic              r_busy;
   logic              r_write_drop;

   logic w_dest_zero;
   logic w_wr_ok;
   logic w_byp_en;

   assign w_dest_zero = (ZERO_REG != 0) && (Add_Dest == '0);
   assign w_wr_ok     = Write_En && !r_busy && !w_dest_zero;
   // Forwarding follows the write-accept rule, so a dropped write is never seen
   assign w_byp_en    = (BYPASS != 0) && Write_En && !r_busy;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_busy       <= 1'b0;
         r_write_drop <= 1'b0;
      end else begin
         r_write_drop <= Write_En && r_busy;
         case (r_state)
            S_IDLE: begin
               // A write coincident with Clear_Req still lands; the clear erases it later
               if (w_wr_ok) r_mem[Add_Dest] <= Write_Data;
               if (Clear_Req) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
                  r_ptr   <= '0;
               end
            end
            S_CLEAR: begin
               r_mem[r_ptr] <= '0;
               r_ptr        <= r_ptr + 1'b1;
               if (r_ptr == {ADDR_W{1'b1}}) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_READ; g++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = Add_R[g*ADDR_W +: ADDR_W];
      assign Info_R[g*DATA_W +: DATA_W] =
         ((ZERO_REG != 0) && (w_addr == '0))   ? '0         :
         (w_byp_en && (Add_Dest == w_addr))    ? Write_Data :
                                                 r_mem[w_addr];
   end

   assign Busy       = r_busy;
   assign Write_Drop = r_write_drop;

endmodule
